plugboard_cfg: RTL and testbench

Run-time programmable Enigma plugboard. It replaces the fixed, hard-wired pair table with a register table of ALPHA entries that is loaded through a config handshake. Symbols enter and leave through a valid/ready stream with a registered output stage. The block sits between the keyboard/UART symbol source and the rotor stack, and is used on both the forward and return paths.

---
 rtl/enigma_pkg.sv | 26 ++
 rtl/plugboard_lane.sv | 47 ++++
 rtl/plugboard_cfg.sv | 181 ++++++++++++++++++
 tb/tb_plugboard_cfg.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// +----------------------------------------------------------------------+
// | enigma_pkg: shared widths, config opcodes and plugboard FSM states.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package enigma_pkg;

  localparam int SYM_W_DEF = 6;
  localparam int ALPHA_DEF = 26;

  localparam logic [1:0] OP_PAIR   = 2'd0;
  localparam logic [1:0] OP_UNPAIR = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNLINK = 2'd1,
    ST_LINK   = 2'd2,
    ST_CLEAR  = 2'd3
  } pb_state_e;

endpackage

`default_nettype wire

// File: rtl/plugboard_lane.sv
// +----------------------------------------------------------------------+
// | plugboard_lane: registered valid/ready stage for one lookup channel. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module plugboard_lane
  import enigma_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_idle,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [SYM_W-1:0] i_mapped,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [SYM_W-1:0] o_out_sym
);

  logic             r_valid;
  logic [SYM_W-1:0] r_sym;
  logic             w_take;

  // Lookups are blocked while the table is being rewritten.
  assign o_in_ready  = i_idle && (!r_valid || i_out_ready);
  assign w_take      = i_in_valid && o_in_ready;
  assign o_out_valid = r_valid;
  assign o_out_sym   = r_sym;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_sym   <= i_mapped;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/plugboard_cfg.sv
// +----------------------------------------------------------------------+
// | plugboard_cfg: run-time programmable Enigma plugboard with config    |
// | FSM. Optional PLUGBOARD_DUAL_CH_EN adds a second lookup channel.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module plugboard_cfg
  import enigma_pkg::*;
#(
  parameter int SYM_W     = SYM_W_DEF,
  parameter int ALPHA     = ALPHA_DEF,
  parameter int MAX_PAIRS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_op,
  input  logic [SYM_W-1:0] cfg_a,
  input  logic [SYM_W-1:0] cfg_b,
  output logic             cfg_err,
  output logic [SYM_W-1:0] pair_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PLUGBOARD_DUAL_CH_EN
  input  logic             in2_valid,
  output logic             in2_ready,
  input  logic [SYM_W-1:0] in2_sym,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [SYM_W-1:0] out2_sym,
`endif
  output logic [SYM_W-1:0] out_sym
);

  localparam int               IDX_W   = $clog2(ALPHA);
  localparam logic [SYM_W-1:0] C_ALPHA = SYM_W'(ALPHA);
  localparam logic [SYM_W:0]   C_MAX   = (SYM_W+1)'(MAX_PAIRS);
  localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(ALPHA - 1);

  pb_state_e        r_state, w_state_nxt;
  logic [SYM_W-1:0] r_tab [ALPHA];
  logic [SYM_W-1:0] r_a, r_b, r_cnt, r_cnt_new;
  logic             r_is_pair, r_err;
  logic [IDX_W-1:0] r_clr_idx;

  logic             w_idle, w_a_ok, w_b_ok, w_real_pair, w_bad, w_accept;
  logic [SYM_W-1:0] w_ta, w_tb, w_unp_res, w_res, w_map1;
  logic [SYM_W:0]   w_pair_res;

  assign w_idle    = (r_state == ST_IDLE);
  assign cfg_ready = w_idle;
  assign cfg_err   = r_err;
  assign pair_cnt  = r_cnt;

  assign w_a_ok = (cfg_a < C_ALPHA);
  assign w_b_ok = (cfg_b < C_ALPHA);
  assign w_ta   = w_a_ok ? r_tab[IDX_W'(cfg_a)] : cfg_a;
  assign w_tb   = w_b_ok ? r_tab[IDX_W'(cfg_b)] : cfg_b;

  // Pair count after the command, evaluated against the current table.
  assign w_pair_res = (SYM_W+1)'(r_cnt) + (SYM_W+1)'(cfg_a != cfg_b)
                    - (SYM_W+1)'(w_ta != cfg_a)
                    - (SYM_W+1)'((w_tb != cfg_b) && (w_tb != cfg_a));
  assign w_unp_res   = r_cnt - SYM_W'(w_ta != cfg_a);
  assign w_real_pair = (cfg_op == OP_PAIR) && (cfg_a != cfg_b);
  assign w_res       = w_real_pair ? w_pair_res[SYM_W-1:0] : w_unp_res;

  assign w_bad = (cfg_op == OP_RSVD) || !w_a_ok
              || ((cfg_op == OP_PAIR) && !w_b_ok)
              || (w_real_pair && (w_pair_res > C_MAX));
  assign w_accept = cfg_valid && w_idle && !w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = (cfg_op == OP_CLEAR) ? ST_CLEAR : ST_UNLINK;
      ST_UNLINK: w_state_nxt = r_is_pair ? ST_LINK : ST_IDLE;
      ST_LINK:   w_state_nxt = ST_IDLE;
      ST_CLEAR:  if (r_clr_idx == C_LAST) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_is_pair <= 1'b0;
      r_cnt_new <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= cfg_valid && w_idle && w_bad;
      if (w_accept) begin
        r_a       <= cfg_a;
        r_b       <= cfg_b;
        r_is_pair <= w_real_pair;
        r_cnt_new <= w_res;
      end
    end
  end

  // Later writes win, so an UNPAIR's self-write overrides the partner release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ALPHA; i++) r_tab[i] <= SYM_W'(i);
      r_cnt     <= '0;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_UNLINK: begin
          r_tab[IDX_W'(r_tab[IDX_W'(r_a)])] <= r_tab[IDX_W'(r_a)];
          if (r_is_pair) begin
            r_tab[IDX_W'(r_tab[IDX_W'(r_b)])] <= r_tab[IDX_W'(r_b)];
          end else begin
            r_tab[IDX_W'(r_a)] <= r_a;
            r_cnt              <= r_cnt_new;
          end
        end
        ST_LINK: begin
          r_tab[IDX_W'(r_a)] <= r_b;
          r_tab[IDX_W'(r_b)] <= r_a;
          r_cnt              <= r_cnt_new;
        end
        ST_CLEAR: begin
          r_tab[r_clr_idx] <= SYM_W'(r_clr_idx);
          if (r_clr_idx == C_LAST) begin
            r_clr_idx <= '0;
            r_cnt     <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_map1 = (in_sym < C_ALPHA) ? r_tab[IDX_W'(in_sym)] : in_sym;

  plugboard_lane #(.SYM_W(SYM_W)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_mapped   (w_map1),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_sym  (out_sym)
  );

`ifdef PLUGBOARD_DUAL_CH_EN
  logic [SYM_W-1:0] w_map2;
  assign w_map2 = (in2_sym < C_ALPHA) ? r_tab[IDX_W'(in2_sym)] : in2_sym;

  plugboard_lane #(.SYM_W(SYM_W)) u_lane2 (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_in_valid (in2_valid),
    .o_in_ready (in2_ready),
    .i_mapped   (w_map2),
    .o_out_valid(out2_valid),
    .i_out_ready(out2_ready),
    .o_out_sym  (out2_sym)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_plugboard_cfg.sv
// +----------------------------------------------------------------------+
// | tb_plugboard_cfg: randomized self-checking bench against a table     |
// | model of the plugboard. Revision: 1.0                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_plugboard_cfg;

  localparam int MAXP = 10;

  logic       clk, rst;
  logic       cfg_valid, cfg_ready, cfg_err;
  logic [1:0] cfg_op;
  logic [5:0] cfg_a, cfg_b, pair_cnt;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [5:0] in_sym, out_sym;

  int n_checks = 0;
  int n_fail   = 0;
  int m_tab [26];

  plugboard_cfg #(.SYM_W(6), .ALPHA(26), .MAX_PAIRS(MAXP)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_err(cfg_err), .pair_cnt(pair_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 26; i++) m_tab[i] = i;
  endfunction

  function automatic int model_pairs();
    int c = 0;
    for (int i = 0; i < 26; i++) if (m_tab[i] != i) c++;
    return c / 2;
  endfunction

  function automatic int model_map(int s);
    return (s < 26) ? m_tab[s] : s;
  endfunction

  // Returns 1 when the command must be rejected; otherwise applies it.
  function automatic bit model_cmd(int op, int a, int b);
    int t [26];
    int p, c;
    if (op == 3 || a >= 26) return 1'b1;
    if (op == 0 && b >= 26) return 1'b1;
    t = m_tab;
    if (op == 2) begin
      for (int i = 0; i < 26; i++) t[i] = i;
    end else begin
      p = t[a]; t[p] = p; t[a] = a;
      if (op == 0 && a != b) begin
        p = t[b]; t[p] = p; t[b] = b;
        t[a] = b; t[b] = a;
      end
    end
    c = 0;
    for (int i = 0; i < 26; i++) if (t[i] != i) c++;
    if (c / 2 > MAXP) return 1'b1;
    m_tab = t;
    return 1'b0;
  endfunction

  function automatic int model_busy(int op, int a, int b, bit err);
    if (err) return 0;
    if (op == 2) return 26;
    if (op == 0 && a != b) return 2;
    return 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cfg_cmd(input int op, input int a, input int b, output bit err, output int busy);
    int n = 0;
    cfg_op = 2'(op); cfg_a = 6'(a); cfg_b = 6'(b); cfg_valid = 1'b1;
    while (!cfg_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin n_checks++; n_fail++; $display("FAIL cfg_ready_timeout got=0 want=1"); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    err  = cfg_err;
    busy = 0;
    while (!cfg_ready && busy < 100) begin @(posedge clk); #1; busy++; end
  endtask

  task automatic send_sym(input int s, output int got, output bit vld);
    int n = 0;
    in_sym = 6'(s); in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin n_checks++; n_fail++; $display("FAIL in_ready_timeout got=0 want=1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = int'(out_sym);
    vld = out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int got; bit vld;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || pair_cnt !== 6'd0 || cfg_err !== 1'b0 || out_sym !== 6'd0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got vld=%0b cnt=%0d err=%0b sym=%0d rdy=%0b want 0/0/0/0/1",
               out_valid, pair_cnt, cfg_err, out_sym, cfg_ready);
    end
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 26; s++) begin
      send_sym(s, got, vld);
      n_checks++;
      if (vld !== 1'b1 || got != model_map(s)) begin
        n_fail++;
        $display("FAIL identity sym=%0d got=%0d vld=%0b want=%0d", s, got, vld, model_map(s));
      end
    end
  endtask

  task automatic test_pair_seq(input int a, input int b, input string nm);
    bit err, exp_err; int busy, got; bit vld;
    int syms [3];
    syms[0] = a; syms[1] = 4; syms[2] = (b == 4) ? 7 : b;
    cfg_cmd(0, a, b, err, busy);
    exp_err = model_cmd(0, a, b);
    n_checks++;
    if (err !== exp_err || busy != model_busy(0, a, b, exp_err) || int'(pair_cnt) != model_pairs()) begin
      n_fail++;
      $display("FAIL %s_cmd got err=%0b busy=%0d cnt=%0d want err=%0b busy=%0d cnt=%0d",
               nm, err, busy, pair_cnt, exp_err, model_busy(0, a, b, exp_err), model_pairs());
    end
    foreach (syms[i]) begin
      send_sym(syms[i], got, vld);
      n_checks++;
      if (vld !== 1'b1 || got != model_map(syms[i])) begin
        n_fail++;
        $display("FAIL %s_map sym=%0d got=%0d want=%0d", nm, syms[i], got, model_map(syms[i]));
      end
    end
  endtask

  task automatic test_overflow();
    bit err, exp_err; int busy, got; bit vld;
    cfg_cmd(2, 0, 0, err, busy);
    void'(model_cmd(2, 0, 0));
    for (int i = 0; i < 10; i++) begin
      cfg_cmd(0, 2 * i, 2 * i + 1, err, busy);
      exp_err = model_cmd(0, 2 * i, 2 * i + 1);
    end
    n_checks++;
    if (int'(pair_cnt) != 10 || model_pairs() != 10) begin
      n_fail++;
      $display("FAIL ovf_load got cnt=%0d want=10", pair_cnt);
    end
    cfg_cmd(0, 20, 21, err, busy);
    exp_err = model_cmd(0, 20, 21);
    n_checks++;
    if (err !== 1'b1 || exp_err !== 1'b1 || busy != 0 || pair_cnt !== 6'd10) begin
      n_fail++;
      $display("FAIL ovf_reject got err=%0b busy=%0d cnt=%0d want err=1 busy=0 cnt=10", err, busy, pair_cnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_err_pulse got=%0b want=0", cfg_err);
    end
    for (int s = 0; s < 26; s++) begin
      send_sym(s, got, vld);
      n_checks++;
      if (got != model_map(s)) begin
        n_fail++; $display("FAIL ovf_table sym=%0d got=%0d want=%0d", s, got, model_map(s));
      end
    end
  endtask

  task automatic test_clear();
    int busy = 0; int rdy_seen = 0; int got; bit vld;
    cfg_op = 2'd2; cfg_a = 6'd0; cfg_b = 6'd0; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    in_valid = 1'b1; in_sym = 6'd3; out_ready = 1'b1;
    while (!cfg_ready && busy < 100) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1; busy++;
    end
    in_valid = 1'b0;
    void'(model_cmd(2, 0, 0));
    @(posedge clk); #1;
    n_checks++;
    if (busy != 26 || rdy_seen != 0 || pair_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL clear_busy got busy=%0d in_ready_seen=%0d cnt=%0d want 26/0/0", busy, rdy_seen, pair_cnt);
    end
    for (int s = 0; s < 26; s++) begin
      send_sym(s, got, vld);
      n_checks++;
      if (got != s) begin n_fail++; $display("FAIL clear_ident sym=%0d got=%0d want=%0d", s, got, s); end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit err; int busy, got; bit vld;
    cfg_cmd(0, 1, 9, err, busy);
    cfg_cmd(0, 2, 15, err, busy);
    cfg_op = 2'd2; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || pair_cnt !== 6'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear got rdy=%0b cnt=%0d vld=%0b want 1/0/0", cfg_ready, pair_cnt, out_valid);
    end
    #1 rst = 1'b0;
    model_reset();
    foreach (m_tab[s]) begin
      send_sym(s, got, vld);
      n_checks++;
      if (got != s) begin n_fail++; $display("FAIL rst_ident sym=%0d got=%0d want=%0d", s, got, s); end
    end
  endtask

  task automatic test_backpressure();
    int s1, s2;
    s1 = 0; s2 = 17;
    void'(model_cmd(0, s1, 11)); begin bit e; int b; cfg_cmd(0, s1, 11, e, b); end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    in_sym = 6'(s1); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_sym = 6'(s2);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || int'(out_sym) != model_map(s1)) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got rdy=%0b vld=%0b sym=%0d want 0/1/%0d", c, in_ready, out_valid, out_sym, model_map(s1));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got rdy=%0b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (int'(out_sym) != model_map(s2)) begin
      n_fail++; $display("FAIL bp_next got=%0d want=%0d", out_sym, model_map(s2));
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got vld=%0b want=0", out_valid); end
    for (int s = 26; s < 64; s += 4) begin
      int got; bit vld;
      send_sym(s, got, vld);
      n_checks++;
      if (got != s) begin n_fail++; $display("FAIL out_of_range sym=%0d got=%0d want=%0d", s, got, s); end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = (i % 5 == 4) ? $urandom_range(26, 63) : $urandom_range(0, 25);
      in_sym = 6'(s);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=0 want=1", i); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || int'(out_sym) != model_map(s)) begin
        n_fail++; $display("FAIL b2b_map sym=%0d got=%0d want=%0d", s, out_sym, model_map(s));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    bit err, exp_err; int busy, pre, got; bit vld;
    pre = model_map(5);
    cfg_op = 2'd0; cfg_a = 6'd5; cfg_b = 6'd6; cfg_valid = 1'b1;
    in_sym = 6'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; in_valid = 1'b0;
    err = cfg_err;
    exp_err = model_cmd(0, 5, 6);
    n_checks++;
    if (int'(out_sym) != pre || out_valid !== 1'b1 || err !== exp_err) begin
      n_fail++;
      $display("FAIL simul_pre got sym=%0d err=%0b want sym=%0d err=%0b", out_sym, err, pre, exp_err);
    end
    busy = 0;
    while (!cfg_ready && busy < 100) begin @(posedge clk); #1; busy++; end
    send_sym(5, got, vld);
    n_checks++;
    if (got != model_map(5)) begin n_fail++; $display("FAIL simul_post got=%0d want=%0d", got, model_map(5)); end
  endtask

  task automatic test_random_cfg();
    bit err, exp_err; int busy, got, op, a, b, r, s; bit vld;
    for (int it = 0; it < 80; it++) begin
      r  = $urandom_range(0, 19);
      op = (r < 12) ? 0 : (r < 17) ? 1 : (r < 18) ? 2 : 3;
      a  = ($urandom_range(0, 15) == 0) ? $urandom_range(26, 63) : $urandom_range(0, 25);
      b  = ($urandom_range(0, 15) == 0) ? $urandom_range(26, 63) : $urandom_range(0, 25);
      cfg_cmd(op, a, b, err, busy);
      exp_err = model_cmd(op, a, b);
      n_checks++;
      if (err !== exp_err || busy != model_busy(op, a, b, exp_err) || int'(pair_cnt) != model_pairs()) begin
        n_fail++;
        $display("FAIL rand_cmd op=%0d a=%0d b=%0d got err=%0b busy=%0d cnt=%0d want err=%0b busy=%0d cnt=%0d",
                 op, a, b, err, busy, pair_cnt, exp_err, model_busy(op, a, b, exp_err), model_pairs());
      end
      for (int k = 0; k < 2; k++) begin
        s = $urandom_range(0, 25);
        send_sym(s, got, vld);
        n_checks++;
        if (got != model_map(s)) begin
          n_fail++; $display("FAIL rand_map sym=%0d got=%0d want=%0d", s, got, model_map(s));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_op = 2'd0; cfg_a = '0; cfg_b = '0;
    in_valid = 1'b0; in_sym = '0; out_ready = 1'b1;
    model_reset();
    test_reset();
    test_pair_seq(0, 4, "basic_pair");
    test_pair_seq(0, 23, "repair");
    test_overflow();
    test_clear();
    test_reset_mid_clear();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_random_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
